// File: rtl/sys_ctrl_pkg.sv
// Shared types and default constants for the system-controller command decoder.
package sys_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StOpa,
      StOpb,
      StFun,
      StWaitRd,
      StWaitAlu
   } state_e;

   localparam int unsigned CMD_WR_DEF      = 'hAA;
   localparam int unsigned CMD_RD_DEF      = 'hBB;
   localparam int unsigned CMD_ALU_OP_DEF  = 'hCC;
   localparam int unsigned CMD_ALU_NOP_DEF = 'hDD;

   localparam int unsigned OPA_ADDR_DEF = 0;
   localparam int unsigned OPB_ADDR_DEF = 1;

endpackage

// File: rtl/sys_ctrl_frame_timer.sv
// Saturating inter-byte timer; o_expire flags the cycle on which the count reaches the limit.
module sys_ctrl_frame_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam bit          Enabled = (TIMEOUT_CYCLES != 0);
   localparam int unsigned CntW    = Enabled ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (Enabled && i_en && (r_cnt != Limit)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Fires on the edge where the count steps onto the limit, so the error lines up with it.
   assign o_expire = Enabled && i_en && !i_clr && (r_cnt == Limit - 1'b1);

endmodule

// File: rtl/sys_ctrl_cmd_dec.sv
// Receive-side command decoder: turns UART RX bytes into register-file and ALU strobes,
// with inter-byte timeout, address range check and completion waits.
module sys_ctrl_cmd_dec
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned FUN_WIDTH      = 4,
   parameter int unsigned OPA_ADDR       = OPA_ADDR_DEF,
   parameter int unsigned OPB_ADDR       = OPB_ADDR_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1023,
   parameter logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(CMD_WR_DEF),
   parameter logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(CMD_RD_DEF),
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(CMD_ALU_OP_DEF),
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(CMD_ALU_NOP_DEF)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic                  alu_out_done,
   input  logic                  rd_data_vld,
   output logic                  EN,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic                  CLK_EN,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic                  busy,
   output logic                  frame_err
);

   state_e                  r_state;
   logic                    r_is_rd;
   logic                    r_en;
   logic [FUN_WIDTH-1:0]    r_alu_fun;
   logic                    r_clk_en;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_wr_en;
   logic                    r_rd_en;
   logic [DATA_WIDTH-1:0]   r_wr_data;
   logic                    r_frame_err;

   logic   w_done;
   logic   w_timed;
   logic   w_expire;
   state_e w_dec_state;

   assign w_done = ((r_state == StWaitRd) && rd_data_vld) ||
                   ((r_state == StWaitAlu) && alu_out_done);
   assign w_timed = (r_state inside {StAddr, StWdata, StOpa, StOpb, StFun});
   // A completion frees the decoder in the same cycle, so a coincident byte starts a new frame.
   assign w_dec_state = w_done ? StIdle : r_state;

   sys_ctrl_frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_clr   (RX_D_VLD),
      .i_en    (w_timed),
      .o_expire(w_expire)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state     <= StIdle;
         r_is_rd     <= 1'b0;
         r_en        <= 1'b0;
         r_alu_fun   <= '0;
         r_clk_en    <= 1'b0;
         r_addr      <= '0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_wr_data   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_en        <= 1'b0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_wr_data   <= '0;
         r_frame_err <= 1'b0;

         if (w_done) begin
            r_state <= StIdle;
            if (r_state == StWaitAlu) begin
               r_clk_en  <= 1'b0;
               r_alu_fun <= '0;
            end
         end

         if (w_expire) begin
            r_frame_err <= 1'b1;
            r_state     <= StIdle;
         end else if (RX_D_VLD) begin
            unique case (w_dec_state)
               StIdle: begin
                  if (RX_P_DATA == CMD_WR || RX_P_DATA == CMD_RD) begin
                     r_is_rd <= (RX_P_DATA == CMD_RD);
                     r_state <= StAddr;
                  end else if (RX_P_DATA == CMD_ALU_OP) begin
                     r_state <= StOpa;
                  end else if (RX_P_DATA == CMD_ALU_NOP) begin
                     r_state <= StFun;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end
               StAddr: begin
                  if (|RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH]) begin
                     r_frame_err <= 1'b1;
                     r_state     <= StIdle;
                  end else begin
                     r_addr <= RX_P_DATA[ADDR_WIDTH-1:0];
                     if (r_is_rd) begin
                        r_rd_en <= 1'b1;
                        r_state <= StWaitRd;
                     end else begin
                        r_state <= StWdata;
                     end
                  end
               end
               StWdata: begin
                  r_wr_en   <= 1'b1;
                  r_wr_data <= RX_P_DATA;
                  r_state   <= StIdle;
               end
               StOpa: begin
                  r_wr_en   <= 1'b1;
                  r_addr    <= ADDR_WIDTH'(OPA_ADDR);
                  r_wr_data <= RX_P_DATA;
                  r_state   <= StOpb;
               end
               StOpb: begin
                  r_wr_en   <= 1'b1;
                  r_addr    <= ADDR_WIDTH'(OPB_ADDR);
                  r_wr_data <= RX_P_DATA;
                  r_state   <= StFun;
               end
               StFun: begin
                  r_alu_fun <= RX_P_DATA[FUN_WIDTH-1:0];
                  r_en      <= 1'b1;
                  r_clk_en  <= 1'b1;
                  r_state   <= StWaitAlu;
               end
               StWaitRd, StWaitAlu: begin
                  r_frame_err <= 1'b1;
               end
               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   assign EN        = r_en;
   assign ALU_FUN   = r_alu_fun;
   assign CLK_EN    = r_clk_en;
   assign Address   = r_addr;
   assign WrEn      = r_wr_en;
   assign RdEn      = r_rd_en;
   assign WrData    = r_wr_data;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_sys_ctrl_cmd_dec.sv
// Bench for sys_ctrl_cmd_dec: directed frames then random traffic, all checked every cycle
// against a frame-level reference model.
module tb_sys_ctrl_cmd_dec;

   localparam int unsigned TO = 1023;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic       alu_out_done;
   logic       rd_data_vld;
   logic       EN;
   logic [3:0] ALU_FUN;
   logic       CLK_EN;
   logic [3:0] Address;
   logic       WrEn;
   logic       RdEn;
   logic [7:0] WrData;
   logic       busy;
   logic       frame_err;

   always #5 CLK = ~CLK;

   sys_ctrl_cmd_dec #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_P_DATA   (RX_P_DATA),
      .RX_D_VLD    (RX_D_VLD),
      .alu_out_done(alu_out_done),
      .rd_data_vld (rd_data_vld),
      .EN          (EN),
      .ALU_FUN     (ALU_FUN),
      .CLK_EN      (CLK_EN),
      .Address     (Address),
      .WrEn        (WrEn),
      .RdEn        (RdEn),
      .WrData      (WrData),
      .busy        (busy),
      .frame_err   (frame_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: bytes collected so far for the open frame, plus what we wait on.
   logic [7:0] m_q[$];
   int         m_wait;   // 0 nothing, 1 read data, 2 ALU result
   int         m_idle;
   logic       e_en, e_wren, e_rden, e_err, e_clken;
   logic [3:0] e_addr, e_fun;
   logic [7:0] e_wdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_decode(input logic [7:0] b);
      int pos;
      logic [7:0] op;
      if (m_q.size() == 0) begin
         if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) m_q.push_back(b);
         else e_err = 1'b1;
         return;
      end
      op  = m_q[0];
      pos = m_q.size();
      if ((op == 8'hAA || op == 8'hBB) && pos == 1) begin
         if (b > 8'd15) begin
            e_err = 1'b1;
            m_q.delete();
         end else begin
            e_addr = b[3:0];
            if (op == 8'hBB) begin
               e_rden = 1'b1;
               m_wait = 1;
               m_q.delete();
            end else begin
               m_q.push_back(b);
            end
         end
      end else if (op == 8'hAA) begin
         e_wren  = 1'b1;
         e_wdata = b;
         m_q.delete();
      end else if (op == 8'hCC && pos < 3) begin
         e_wren  = 1'b1;
         e_wdata = b;
         e_addr  = (pos == 1) ? 4'd0 : 4'd1;
         m_q.push_back(b);
      end else begin
         e_fun   = b[3:0];
         e_en    = 1'b1;
         e_clken = 1'b1;
         m_wait  = 2;
         m_q.delete();
      end
   endtask

   task automatic model_step(input logic rst, input logic vld, input logic [7:0] b,
                             input logic rdv, input logic ad);
      e_en = 1'b0; e_wren = 1'b0; e_rden = 1'b0; e_err = 1'b0; e_wdata = 8'h00;
      if (!rst) begin
         m_q.delete();
         m_wait = 0; m_idle = 0;
         e_addr = 4'h0; e_fun = 4'h0; e_clken = 1'b0;
         return;
      end
      if (m_wait == 1 && rdv) begin
         m_wait = 0;
      end else if (m_wait == 2 && ad) begin
         m_wait  = 0;
         e_clken = 1'b0;
         e_fun   = 4'h0;
      end
      if (vld) begin
         m_idle = 0;
         if (m_wait != 0) e_err = 1'b1;
         else model_decode(b);
      end else if (m_q.size() > 0) begin
         if (m_idle < int'(TO)) m_idle++;
         if (m_idle == int'(TO)) begin
            e_err = 1'b1;
            m_q.delete();
         end
      end
   endtask

   task automatic compare_all();
      check("EN", EN, e_en);
      check("WrEn", WrEn, e_wren);
      check("RdEn", RdEn, e_rden);
      check("WrData", WrData, e_wdata);
      check("frame_err", frame_err, e_err);
      check("Address", Address, e_addr);
      check("ALU_FUN", ALU_FUN, e_fun);
      check("CLK_EN", CLK_EN, e_clken);
      check("busy", busy, (m_q.size() > 0) || (m_wait != 0));
   endtask

   // One clock: drive after the falling edge, model at the rising edge, sample at the next fall.
   task automatic cyc(input logic rst, input logic vld, input logic [7:0] b,
                      input logic rdv, input logic ad);
      RST          = rst;
      RX_D_VLD     = vld;
      RX_P_DATA    = vld ? b : 8'($urandom);
      rd_data_vld  = rdv;
      alu_out_done = ad;
      @(posedge CLK);
      model_step(rst, vld, b, rdv, ad);
      @(negedge CLK);
      compare_all();
   endtask

   task automatic send(input logic [7:0] b);
      cyc(1'b1, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   function automatic logic rnd_pulse();
      return ($urandom_range(0, 4) == 0);
   endfunction

   task automatic rnd_idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, rnd_pulse(), rnd_pulse());
   endtask

   initial begin
      logic [7:0] fr[$];
      int kind;
      m_wait = 0; m_idle = 0;
      RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00; rd_data_vld = 1'b0; alu_out_done = 1'b0;
      @(negedge CLK);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);

      send(8'hAA); send(8'h05); send(8'h3C); idle(2);
      send(8'hBB); send(8'h07); idle(3); cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0); idle(1);
      send(8'hCC); send(8'h12); send(8'h34); send(8'h02); idle(2);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1); idle(1);
      send(8'h55); idle(1);
      send(8'hAA); send(8'h15); idle(2);
      send(8'hAA); idle(TO + 2);
      send(8'hAA); idle(TO - 1); send(8'h01); send(8'hFF); idle(2);
      send(8'hCC); send(8'h11); send(8'h22);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      send(8'hDD); send(8'h03); idle(1); cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1); idle(1);
      send(8'hDD); send(8'h04); send(8'h77); idle(1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      send(8'hDD); send(8'h05); cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      send(8'h02); send(8'h99); idle(2);
      send(8'hBB); send(8'h03); cyc(1'b1, 1'b1, 8'hDD, 1'b1, 1'b0);
      send(8'h0E); idle(1); cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

      for (int f = 0; f < 300; f++) begin
         fr.delete();
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1: begin
               fr.push_back(8'hAA); fr.push_back(8'($urandom_range(0, 15)));
               fr.push_back(8'($urandom));
            end
            2: begin
               fr.push_back(8'hBB); fr.push_back(8'($urandom_range(0, 15)));
            end
            3, 4: begin
               fr.push_back(8'hCC);
               for (int k = 0; k < 3; k++) fr.push_back(8'($urandom));
            end
            5: begin
               fr.push_back(8'hDD); fr.push_back(8'($urandom));
            end
            6: fr.push_back(8'($urandom));
            7: begin
               fr.push_back(($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB);
               fr.push_back(8'($urandom_range(16, 255)));
            end
            default: begin
               fr.push_back(8'hCC); fr.push_back(8'($urandom));
            end
         endcase
         foreach (fr[k]) begin
            rnd_idle($urandom_range(0, 2));
            cyc(1'b1, 1'b1, fr[k], rnd_pulse(), rnd_pulse());
         end
         if (kind == 8) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
         end else if (kind == 9) begin
            if ($urandom_range(0, 3) == 0) rnd_idle(TO - 1 + $urandom_range(0, 2));
            else rnd_idle($urandom_range(0, 10));
         end
         rnd_idle($urandom_range(0, 5));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
